signed_serial_parallel_multiplier: RTL and testbench
====================================================

Name: signed_serial_parallel_multiplier

Overview:
- Parametrised, mode-selectable serial-parallel multiplier; successor to the fixed 8-bit unsigned serial multiplier.
- Consumes one multiplier bit per clock, LSB first, against a parallel multiplicand.
- Adds a signed (two's complement) or unsigned mode per operation, a ready/start handshake and a synchronous abort.
- Used as a low-area multiply unit in datapaths where WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- start  input  1  request a multiply; accepted only on an edge where ready=1
- signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned; sampled with start
- abort  input  1  synchronous cancel of an operation in progress
- multiplicand  input  WIDTH  parallel operand A; sampled with start
- multiplier  input  WIDTH  serial operand B; sampled with start
- ready  output  1  block idle, start will be accepted
- busy  output  1  operation in progress (state RUN)
- product  output  2*WIDTH  result; holds until the next accepted start or reset
- done  output  1  one-cycle pulse, product newly valid

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, product=0, done=0, busy=0, ready=1, internal A/B/accumulator/counter=0. Reset mid-operation discards the operation with no done.
- States: IDLE, RUN, DONE. ready=(state==IDLE); busy=(state==RUN). Both are decoded from state.
- IDLE: when start=1 at an edge, latch A, B and mode, clear the accumulator and counter, and go to RUN. start=0 stays in IDLE. start while not IDLE is ignored, with no queueing.
- Operand extension at latch:
  - Signed mode: A is sign-extended to 2*WIDTH.
  - Unsigned mode: A is zero-extended.
- RUN: each edge handles bit i of B (i = counter, 0..WIDTH-1):
  - If B[i]=1 and i<WIDTH-1, add (A_ext << i) to the accumulator.
  - If B[i]=1, i=WIDTH-1 and signed mode, subtract (A_ext << i), because the MSB has negative weight.
  - If B[i]=1, i=WIDTH-1 and unsigned mode, add (A_ext << i).
  - All arithmetic is modulo 2^(2*WIDTH).
- At the edge processing i=WIDTH-1, register the final value (including the last step) into product, set done=1 and go to DONE.
- DONE: lasts one cycle. On the next edge done=0 and the state goes to IDLE.
- Latency: a start accepted at edge E0 gives product and done=1 after edge E_WIDTH. done falls and ready rises after E_(WIDTH+1). Back-to-back throughput is one result per WIDTH+2 cycles.
- A start asserted during the DONE cycle is ignored; the source must hold start until ready=1.
- abort=1 at an edge while in RUN: go to IDLE, no done, product keeps its previous value. abort has priority over completion on the final step. abort is ignored in IDLE and DONE. If abort and start are both 1 in IDLE, start is accepted.
- Counter width is clog2(WIDTH)+1, so there is no wrap at WIDTH=32.
- Result is exact, with no overflow, for all operand pairs in both modes, including the signed corners (-2^(W-1))*(-2^(W-1)) and (2^(W-1)-1)*(-2^(W-1)).
- product changes only at completion or reset; never during RUN.

Test Plan:
- WIDTH=8, signed_mode=1, A=0xFD (-3), B=0x05 -> done exactly 8 edges after acceptance, product=0xFFF1 (-15); ready low for 9 cycles.
- Same operands, signed_mode=0 -> product=0x04F1 (253*5=1265).
- WIDTH=8 signed corners: 0x80*0x80 -> 0x4000; 0x7F*0x80 -> 0xC080; unsigned 0xFF*0xFF -> 0xFE01.
- start pulsed while busy (mid-RUN) and during the DONE cycle with different operands -> ignored; first result is unchanged and no second done until start is re-asserted with ready=1.
- abort at bit 3 of A=0x12, B=0x34 after a prior result 0x0100 -> no done, product stays 0x0100, ready=1 next cycle. Separately, rst=0 mid-RUN -> all outputs at reset values immediately, with no clock edge required.
- Parameter sweep WIDTH=2,5,16,32: 1000 random operand/mode pairs each, compared against a signed/unsigned reference model -> zero mismatches, done pulse exactly one cycle each time.

Source files
------------

// File: rtl/signed_serial_parallel_multiplier.sv
// Serial-parallel multiplier: one multiplier bit per clock, LSB first, against a
// parallel multiplicand, with signed/unsigned mode, ready/start handshake and abort.
module signed_serial_parallel_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            mode_q, mode_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            done_q, done_d;

    logic            last_step;
    logic [PW-1:0]   step_sum;
    logic [PW-1:0]   a_ext;

    // a_q is pre-shifted every step, so it already equals A_ext << counter; the
    // MSB of a signed multiplier carries negative weight and is subtracted.
    always_comb begin
        last_step = (cnt_q == LAST_CNT);
        step_sum  = acc_q;
        if (b_q[0]) begin
            if (last_step && mode_q) begin
                step_sum = acc_q - a_q;
            end else begin
                step_sum = acc_q + a_q;
            end
        end else begin
            step_sum = acc_q;
        end
    end

    // Sign- or zero-extend the multiplicand as it is latched.
    always_comb begin
        a_ext = {{WIDTH{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_ext;
                    b_d     = multiplier;
                    mode_d  = signed_mode;
                    acc_d   = {PW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_step) begin
                        product_d = step_sum;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= {PW{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            mode_q    <= 1'b0;
            acc_q     <= {PW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {PW{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign product = product_q;
    assign done    = done_q;

endmodule

// File: tb/tb_signed_serial_parallel_multiplier.sv
// Bench for signed_serial_parallel_multiplier: directed table and corner sequences
// at WIDTH=8, plus random sweeps at WIDTH=2,5,16,32 against an arithmetic model.
module tb_signed_serial_parallel_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // WIDTH=8 instance for directed checks
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic        abort;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        busy;
    logic [15:0] product;
    logic        done;

    signed_serial_parallel_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .abort(abort),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .ready(ready), .busy(busy), .product(product), .done(done)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        m;
        logic [15:0] exp;
    } vec_t;

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          output logic [15:0] p, output int lat, output int rdy_low);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = m;
        start        = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 0;
        rdy_low = 0;
        while (!done && lat < 40) begin
            if (!ready) rdy_low++;
            tick();
            lat++;
        end
        if (!ready) rdy_low++;
        p = product;
    endtask

    // Random sweep instances, each with its own reset and arithmetic reference
    localparam int SW [4] = '{2, 5, 16, 32};

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W = SW[g];
        logic           s_rst;
        logic           s_start;
        logic           s_mode;
        logic           s_abort;
        logic [W-1:0]   s_a;
        logic [W-1:0]   s_b;
        logic           s_ready;
        logic           s_busy;
        logic [2*W-1:0] s_p;
        logic           s_done;
        int             sv = 0;
        int             se = 0;
        logic           fin = 1'b0;

        signed_serial_parallel_multiplier #(.WIDTH(W)) u_dut (
            .clk(clk), .rst(s_rst), .start(s_start), .signed_mode(s_mode), .abort(s_abort),
            .multiplicand(s_a), .multiplier(s_b),
            .ready(s_ready), .busy(s_busy), .product(s_p), .done(s_done)
        );

        function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic m);
            logic [63:0] ae;
            logic [63:0] be;
            logic [63:0] pr;
            ae = m ? 64'($signed(a)) : 64'(a);
            be = m ? 64'($signed(b)) : 64'(b);
            pr = ae * be;
            return pr[2*W-1:0];
        endfunction

        task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
            sv++;
            if (act !== exp) begin
                se++;
                $display("FAIL sweep_w%0d_%s: got 0x%0h, expected 0x%0h", W, name, act, exp);
            end
        endtask

        initial begin
            int lat;
            s_rst   = 1'b0;
            s_start = 1'b0;
            s_mode  = 1'b0;
            s_abort = 1'b0;
            s_a     = '0;
            s_b     = '0;
            tick();
            tick();
            s_rst = 1'b1;
            tick();
            for (int i = 0; i < 1000; i++) begin
                s_a     = W'($urandom);
                s_b     = W'($urandom);
                s_mode  = 1'($urandom_range(0, 1));
                s_start = 1'b1;
                tick();
                s_start = 1'b0;
                lat     = 0;
                while (!s_done && lat < W + 8) begin
                    tick();
                    lat++;
                end
                chk("latency", 64'(lat), 64'(W));
                chk("product", 64'(s_p), 64'(ref_mul(s_a, s_b, s_mode)));
                tick();
                chk("done_pulse", {63'd0, s_done}, 64'd0);
            end
            fin = 1'b1;
        end
    end

    initial begin
        vec_t        tbl [10];
        logic [15:0] p;
        int          lat;
        int          rl;
        int          c;

        tbl[0] = '{a: 8'hFD, b: 8'h05, m: 1'b1, exp: 16'hFFF1};
        tbl[1] = '{a: 8'hFD, b: 8'h05, m: 1'b0, exp: 16'h04F1};
        tbl[2] = '{a: 8'h80, b: 8'h80, m: 1'b1, exp: 16'h4000};
        tbl[3] = '{a: 8'h7F, b: 8'h80, m: 1'b1, exp: 16'hC080};
        tbl[4] = '{a: 8'hFF, b: 8'hFF, m: 1'b0, exp: 16'hFE01};
        tbl[5] = '{a: 8'hFF, b: 8'hFF, m: 1'b1, exp: 16'h0001};
        tbl[6] = '{a: 8'h7F, b: 8'h7F, m: 1'b1, exp: 16'h3F01};
        tbl[7] = '{a: 8'h01, b: 8'h80, m: 1'b0, exp: 16'h0080};
        tbl[8] = '{a: 8'h80, b: 8'h01, m: 1'b1, exp: 16'hFF80};
        tbl[9] = '{a: 8'h00, b: 8'hFF, m: 1'b1, exp: 16'h0000};

        rst          = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        abort        = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        #2;
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", 64'(product), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].m, p, lat, rl);
            check($sformatf("tbl%0d_product", i), 64'(p), 64'(tbl[i].exp));
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd8);
            check($sformatf("tbl%0d_ready_low", i), 64'(rl), 64'd9);
            tick();
            check($sformatf("tbl%0d_done_pulse", i), {63'd0, done}, 64'd0);
            check($sformatf("tbl%0d_ready_back", i), {63'd0, ready}, 64'd1);
        end

        // start while RUN and during DONE must be ignored
        multiplicand = 8'h03;
        multiplier   = 8'h04;
        signed_mode  = 1'b0;
        start        = 1'b1;
        tick();
        for (c = 1; c <= 8; c++) begin
            start        = (c == 3);
            multiplicand = 8'h55;
            multiplier   = 8'h55;
            tick();
        end
        start = 1'b0;
        check("ignore_done", {63'd0, done}, 64'd1);
        check("ignore_product", 64'(product), 64'h000C);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_done_fall", {63'd0, done}, 64'd0);
        check("ignore_ready", {63'd0, ready}, 64'd1);
        c = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) c++;
            tick();
        end
        check("ignore_no_second_op", 64'(c), 64'd0);
        check("ignore_product_held", 64'(product), 64'h000C);
        run_op(8'h55, 8'h55, 1'b0, p, lat, rl);
        check("restart_product", 64'(p), 64'h1C39);
        tick();

        // abort on the edge that processes bit 3
        run_op(8'h10, 8'h10, 1'b0, p, lat, rl);
        check("prior_product", 64'(p), 64'h0100);
        tick();
        multiplicand = 8'h12;
        multiplier   = 8'h34;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_product", 64'(product), 64'h0100);
        c = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) c++;
            tick();
        end
        check("abort_no_late_done", 64'(c), 64'd0);
        check("abort_product_held", 64'(product), 64'h0100);

        // asynchronous reset in the middle of RUN
        multiplicand = 8'h12;
        multiplier   = 8'h34;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ready", {63'd0, ready}, 64'd1);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_product", 64'(product), 64'd0);
        #2;
        rst = 1'b1;
        c = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) c++;
        end
        check("rst_no_done", 64'(c), 64'd0);

        c = 0;
        while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin)
               && c < 60000) begin
            tick();
            c++;
        end
        check("sweeps_finished",
              {60'd0, g_sweep[3].fin, g_sweep[2].fin, g_sweep[1].fin, g_sweep[0].fin}, 64'hF);
        n_vec = n_vec + g_sweep[0].sv + g_sweep[1].sv + g_sweep[2].sv + g_sweep[3].sv;
        n_err = n_err + g_sweep[0].se + g_sweep[1].se + g_sweep[2].se + g_sweep[3].se;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
